sys_mem_responder: RTL

Responder end of the system memory bus driven by the master SH7604 side of the Saturn top level. Decodes `ROM_CS_N`, `RAML_CS_N` and `RAMH_CS_N` with their address, byte-lane and read strobes. Converts each bus cycle into a single request/acknowledge transaction on a 32-bit backing-memory port, such as an SDRAM or BRAM arbiter. Returns read data on `MEM_DI` and stretches the CPU cycle through `MEM_WAIT_N` until the data is valid.

---
 rtl/sys_mem_pkg.sv | 19 +
 rtl/sys_mem_decode.sv | 54 +++++
 rtl/sys_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sys_mem_pkg.sv
// Shared types and constants for the system memory bus responder.
package sys_mem_pkg;

  // Transaction state: waiting for a CS, request outstanding, cycle finished.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Region code placed in SD_A[19:18].
  localparam logic [1:0] REG_ROM  = 2'b00;
  localparam logic [1:0] REG_RAML = 2'b01;
  localparam logic [1:0] REG_RAMH = 2'b10;

  // Default request timeout in CLK cycles.
  localparam int TO_CYC_DEFAULT = 255;

endpackage

// File: rtl/sys_mem_decode.sv
// Combinational bus decode: CS priority (RAMH > RAML > ROM), region code,
// backing word address, byte enables and the "no request needed" flag.
module sys_mem_decode
  import sys_mem_pkg::*;
#(
  parameter int ROM_AW = 17,
  parameter int RAM_AW = 18
) (
  input  logic [24:0] mem_a,
  input  logic [3:0]  mem_dqm_n,
  input  logic        mem_rd_n,
  input  logic        rom_cs_n,
  input  logic        raml_cs_n,
  input  logic        ramh_cs_n,
  output logic        any_cs,
  output logic        multi_cs,
  output logic [19:0] word_addr,
  output logic [3:0]  byte_en,
  output logic        skip_req
);

  logic [1:0]  region;
  logic [17:0] rom_off;
  logic [17:0] ram_off;
  logic        unused_a;

  // Word offsets; the ROM window is narrower and zero-extended.
  assign rom_off = 18'(mem_a[ROM_AW+1:2]);
  assign ram_off = 18'(mem_a[RAM_AW+1:2]);

  // Byte-lane bits and address bits above the largest window are don't-care.
  assign unused_a = ^{mem_a[24:20], mem_a[1:0]};

  // Region select with RAMH taking priority over RAML over ROM.
  always_comb begin
    // NOTE: default assigned first so every path drives region and no latch is inferred.
    region = REG_ROM;
    if (!ramh_cs_n)      region = REG_RAMH;
    else if (!raml_cs_n) region = REG_RAML;
  end

  assign any_cs   = !(rom_cs_n && raml_cs_n && ramh_cs_n);
  assign multi_cs = (!rom_cs_n && !raml_cs_n) || (!rom_cs_n && !ramh_cs_n) ||
                    (!raml_cs_n && !ramh_cs_n);

  assign word_addr = {region, (region == REG_ROM) ? rom_off : ram_off};

  // Reads always fetch the full word; writes use the CPU lane strobes.
  assign byte_en = mem_rd_n ? ~mem_dqm_n : 4'hF;

  // ROM writes and writes with no lane enabled complete without a request.
  assign skip_req = mem_rd_n && ((region == REG_ROM) || (mem_dqm_n == 4'hF));

endmodule

// File: rtl/sys_mem_responder.sv
// System memory bus responder: turns each SH7604 ROM/RAML/RAMH bus cycle into
// one request/acknowledge transaction on a 32-bit backing-memory port and
// stretches the CPU cycle with MEM_WAIT_N until the transaction completes.
// Optional request timeout: define SYS_MEM_RESP_TIMEOUT_EN.
module sys_mem_responder
  import sys_mem_pkg::*;
#(
  parameter int ROM_AW = 17,
  parameter int RAM_AW = 18,
  parameter int TO_CYC = TO_CYC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [24:0] MEM_A,
  input  logic [31:0] MEM_DO,
  input  logic [3:0]  MEM_DQM_N,
  input  logic        MEM_RD_N,
  input  logic        ROM_CS_N,
  input  logic        RAML_CS_N,
  input  logic        RAMH_CS_N,
  output logic [31:0] MEM_DI,
  output logic        MEM_WAIT_N,
  output logic [19:0] SD_A,
  output logic        SD_REQ,
  output logic        SD_WE,
  output logic [3:0]  SD_BE,
  output logic [31:0] SD_D,
  input  logic [31:0] SD_Q,
  input  logic        SD_ACK,
  output logic        ERR
);

  mem_state_t  state;
  mem_state_t  state_nxt;
  logic        any_cs;
  logic        multi_cs;
  logic [19:0] word_addr;
  logic [3:0]  byte_en;
  logic        skip_req;
  logic        accept;
  logic        timeout;

  sys_mem_decode #(
    .ROM_AW (ROM_AW),
    .RAM_AW (RAM_AW)
  ) u_decode (
    .mem_a     (MEM_A),
    .mem_dqm_n (MEM_DQM_N),
    .mem_rd_n  (MEM_RD_N),
    .rom_cs_n  (ROM_CS_N),
    .raml_cs_n (RAML_CS_N),
    .ramh_cs_n (RAMH_CS_N),
    .any_cs    (any_cs),
    .multi_cs  (multi_cs),
    .word_addr (word_addr),
    .byte_en   (byte_en),
    .skip_req  (skip_req)
  );

  // A new bus cycle is taken only on a bus-enable cycle while idle.
  assign accept = (state == ST_IDLE) && CE_R && any_cs;

`ifdef SYS_MEM_RESP_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Cycles spent in REQ; held at zero elsewhere so it starts clean on entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                to_cnt <= '0;
    else if (state != ST_REQ)  to_cnt <= '0;
    else                       to_cnt <= to_cnt + 8'd1;
  end

  assign timeout = (state == ST_REQ) && !SD_ACK && (to_cnt == 8'(TO_CYC - 1));
`else
  logic [31:0] unused_to_cyc;

  assign timeout       = 1'b0;
  assign unused_to_cyc = 32'(TO_CYC);
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one transaction per CS assertion; DONE waits for CS to go high.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)            state_nxt = skip_req ? ST_DONE : ST_REQ;
      ST_REQ:  if (SD_ACK || timeout) state_nxt = ST_DONE;
      ST_DONE: if (CE_R && !any_cs)   state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  assign SD_REQ     = (state == ST_REQ);
  assign MEM_WAIT_N = !(((state == ST_IDLE) && any_cs) || (state == ST_REQ));

  // Request fields latched at accept, read data captured on ack, sticky error.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SD_A   <= '0;
      SD_WE  <= 1'b0;
      SD_BE  <= '0;
      SD_D   <= '0;
      MEM_DI <= '0;
      ERR    <= 1'b0;
    end else begin
      if (accept) begin
        if (multi_cs) ERR <= 1'b1;
        if (!skip_req) begin
          SD_A  <= word_addr;
          SD_WE <= MEM_RD_N;
          SD_BE <= byte_en;
          SD_D  <= MEM_DO;
        end
      end
      if ((state == ST_REQ) && SD_ACK && !SD_WE) MEM_DI <= SD_Q;
      if (timeout) begin
        ERR <= 1'b1;
        if (!SD_WE) MEM_DI <= 32'hFFFF_FFFF;
      end
    end
  end

endmodule
